// File: rtl/timer_pkg.sv
// Shared encodings and defaults for the timer count stages.
package timer_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_SAT  = 1'b0,
    MODE_WRAP = 1'b1
  } mode_e;

  localparam int TIMER_WIDTH = 8;

endpackage

// File: rtl/timer_counter_if.sv
// Control and status bundle for one timer count stage; master drives controls, slave is the counter.
interface timer_counter_if
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) ();

  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             dir;
  logic             wrap;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             done;

  modport master (
    output clr, load, load_val, en, dir, wrap,
    input  count, tc, done
  );

  modport slave (
    input  clr, load, load_val, en, dir, wrap,
    output count, tc, done
  );

endinterface

// File: rtl/inc_dec_n.sv
// Combinational +/-1 modulo 2**WIDTH built as a toggle chain: bit i flips when all lower bits
// equal dir (all ones going up, all zeros going down).
module inc_dec_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in,
  input  logic             dir,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] chain;

  always_comb begin
    chain    = '0;
    chain[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      chain[i] = chain[i-1] & (in[i-1] ~^ dir);
    end
  end

  assign out = in ^ chain;

endmodule

// File: rtl/timer_counter.sv
// Registered up/down count stage with programmable terminal value, wrap/saturate, load/clear and tc pulse.
// One-cycle latency from an enabled edge to count/tc/done; no combinational input-to-output path.
module timer_counter
  import timer_pkg::*;
#(
  parameter int          WIDTH     = TIMER_WIDTH,
  parameter int unsigned MAX_COUNT = (2 ** WIDTH) - 1
) (
  input  logic           clk,
  input  logic           rst_n,
  timer_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_V = MAX_COUNT[WIDTH-1:0];

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] wrap_val;
  logic             at_bound;
  logic             going_up;

  inc_dec_n #(.WIDTH(WIDTH)) u_step (
    .in  (count_q),
    .dir (bus.dir),
    .out (step_val)
  );

  assign going_up     = (bus.dir == DIR_UP);
  assign load_clamped = (bus.load_val > MAX_V) ? MAX_V : bus.load_val;
  assign at_bound     = going_up ? (count_q == MAX_V) : (count_q == '0);
  assign wrap_val     = going_up ? '0 : MAX_V;

  always_comb begin
    count_d = count_q;
    done_d  = done_q;
    tc_d    = 1'b0;
    if (bus.clr) begin
      count_d = '0;
      done_d  = 1'b0;
    end else if (bus.load) begin
      count_d = load_clamped;
      done_d  = 1'b0;
    end else if (bus.en && !done_q) begin
      // A saturated stage stays frozen until clr/load, whatever dir/wrap do meanwhile.
      if (!at_bound) begin
        count_d = step_val;
      end else if (bus.wrap == MODE_WRAP) begin
        count_d = wrap_val;
        tc_d    = 1'b1;
      end else begin
        tc_d   = 1'b1;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: expectations queued as stimulus is driven, popped when outputs settle.
module tb_timer_counter;
  import timer_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  timer_counter_if #(.WIDTH(8)) a ();
  timer_counter_if #(.WIDTH(4)) b ();
  timer_counter_if #(.WIDTH(4)) c0 ();
  timer_counter_if #(.WIDTH(4)) c1 ();

  timer_counter #(.WIDTH(8), .MAX_COUNT(59)) u_a  (.clk(clk), .rst_n(rst_n), .bus(a));
  timer_counter #(.WIDTH(4), .MAX_COUNT(15)) u_b  (.clk(clk), .rst_n(rst_n), .bus(b));
  timer_counter #(.WIDTH(4), .MAX_COUNT(9))  u_c0 (.clk(clk), .rst_n(rst_n), .bus(c0));
  timer_counter #(.WIDTH(4), .MAX_COUNT(9))  u_c1 (.clk(clk), .rst_n(rst_n), .bus(c1));

  assign c1.en = c0.tc;

  typedef struct {
    string tag;
    int    cnt;
    logic  tc;
    logic  done;
  } exp_t;

  exp_t sbq[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   pulses  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic expect_push(input string tag, input int c, input logic t, input logic d);
    exp_t e;
    e.tag  = tag;
    e.cnt  = c;
    e.tc   = t;
    e.done = d;
    sbq.push_back(e);
  endtask

  task automatic check_out(input logic [31:0] c, input logic t, input logic d);
    exp_t e;
    if (sbq.size() == 0) begin
      $display("FAIL scoreboard: got empty queue expected an entry");
      $fatal(1, "scoreboard underflow");
    end
    e = sbq.pop_front();
    chk({e.tag, "_count"}, c, e.cnt);
    chk({e.tag, "_tc"}, {31'd0, t}, {31'd0, e.tc});
    chk({e.tag, "_done"}, {31'd0, d}, {31'd0, e.done});
  endtask

  task automatic step_a(input logic c, input logic l, input logic [7:0] lv, input logic e,
                        input logic d, input logic w, input string tag,
                        input int ec, input logic et, input logic ed);
    @(negedge clk);
    a.clr = c; a.load = l; a.load_val = lv; a.en = e; a.dir = d; a.wrap = w;
    expect_push(tag, ec, et, ed);
    @(posedge clk);
    #1;
    check_out({24'd0, a.count}, a.tc, a.done);
  endtask

  task automatic step_b(input logic c, input logic l, input logic [3:0] lv, input logic e,
                        input logic d, input logic w, input string tag,
                        input int ec, input logic et, input logic ed);
    @(negedge clk);
    b.clr = c; b.load = l; b.load_val = lv; b.en = e; b.dir = d; b.wrap = w;
    expect_push(tag, ec, et, ed);
    @(posedge clk);
    #1;
    check_out({28'd0, b.count}, b.tc, b.done);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a.clr = 0; a.load = 0; a.load_val = '0; a.en = 0; a.dir = DIR_UP; a.wrap = MODE_WRAP;
    b.clr = 0; b.load = 0; b.load_val = '0; b.en = 0; b.dir = DIR_UP; b.wrap = MODE_WRAP;
    c0.clr = 0; c0.load = 0; c0.load_val = '0; c0.en = 0; c0.dir = DIR_UP; c0.wrap = MODE_WRAP;
    c1.clr = 0; c1.load = 0; c1.load_val = '0; c1.dir = DIR_UP; c1.wrap = MODE_WRAP;

    #1 rst_n = 1'b0;
    #2;
    expect_push("reset_a", 0, 1'b0, 1'b0);
    check_out({24'd0, a.count}, a.tc, a.done);
    expect_push("reset_c1", 0, 1'b0, 1'b0);
    check_out({28'd0, c1.count}, c1.tc, c1.done);
    @(negedge clk);
    rst_n = 1'b1;

    // Count up to 17, then yank reset between edges.
    for (int i = 1; i <= 17; i++) step_a(0, 0, 8'd0, 1, DIR_UP, MODE_WRAP, "up17", i, 0, 0);
    @(negedge clk);
    a.en = 0;
    #1 rst_n = 1'b0;
    #1;
    expect_push("async_rst", 0, 1'b0, 1'b0);
    check_out({24'd0, a.count}, a.tc, a.done);
    #1 rst_n = 1'b1;

    // Up wrap at MAX_COUNT=59.
    step_a(0, 1, 8'd58, 0, DIR_UP, MODE_WRAP, "ldw58", 58, 0, 0);
    step_a(0, 0, 8'd0,  1, DIR_UP, MODE_WRAP, "upw1",  59, 0, 0);
    step_a(0, 0, 8'd0,  1, DIR_UP, MODE_WRAP, "upw2",  0,  1, 0);
    step_a(0, 0, 8'd0,  1, DIR_UP, MODE_WRAP, "upw3",  1,  0, 0);

    // Down saturate: terminal step happens on the edge after 0 is first reached.
    step_a(0, 1, 8'd2, 0, DIR_DOWN, MODE_SAT, "ld2",   2, 0, 0);
    step_a(0, 0, 8'd0, 1, DIR_DOWN, MODE_SAT, "dns1",  1, 0, 0);
    step_a(0, 0, 8'd0, 1, DIR_DOWN, MODE_SAT, "dns2",  0, 0, 0);
    step_a(0, 0, 8'd0, 1, DIR_DOWN, MODE_SAT, "dns3",  0, 1, 1);
    step_a(0, 0, 8'd0, 1, DIR_DOWN, MODE_SAT, "dns4",  0, 0, 1);
    step_a(0, 0, 8'd0, 1, DIR_DOWN, MODE_SAT, "dns5",  0, 0, 1);
    step_a(0, 0, 8'd0, 1, DIR_UP,   MODE_SAT, "flipup", 0, 0, 1);
    step_a(0, 0, 8'd0, 0, DIR_UP,   MODE_SAT, "idle",  0, 0, 1);

    // Priority clr > load > en, and load clamp.
    step_a(1, 1, 8'd30,  1, DIR_UP, MODE_SAT, "prio",   0,  0, 0);
    step_a(0, 1, 8'd200, 0, DIR_UP, MODE_SAT, "clamp",  59, 0, 0);
    step_a(0, 0, 8'd0,   1, DIR_UP, MODE_SAT, "ups1",   59, 1, 1);
    step_a(0, 0, 8'd0,   1, DIR_UP, MODE_SAT, "ups2",   59, 0, 1);
    step_a(0, 1, 8'd10,  1, DIR_UP, MODE_SAT, "ldoven", 10, 0, 0);

    // Full 4-bit range, both wrap directions.
    step_b(1, 0, 4'd0,  0, DIR_DOWN, MODE_WRAP, "b_clr", 0,  0, 0);
    step_b(0, 0, 4'd0,  1, DIR_DOWN, MODE_WRAP, "b_dn1", 15, 1, 0);
    step_b(0, 0, 4'd0,  1, DIR_DOWN, MODE_WRAP, "b_dn2", 14, 0, 0);
    step_b(0, 1, 4'd15, 0, DIR_UP,   MODE_WRAP, "b_ld",  15, 0, 0);
    step_b(0, 0, 4'd0,  1, DIR_UP,   MODE_WRAP, "b_up1", 0,  1, 0);
    step_b(0, 0, 4'd0,  1, DIR_UP,   MODE_WRAP, "b_up2", 1,  0, 0);

    // Cascade: stage1 sees its tenth enable one edge after stage0's hundredth step.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      c0.en = 1'b1;
      @(posedge clk);
      #1;
      if (c1.tc) pulses++;
    end
    expect_push("c0_100", 0, 1'b1, 1'b0);
    check_out({28'd0, c0.count}, c0.tc, c0.done);
    expect_push("c1_100", 9, 1'b0, 1'b0);
    check_out({28'd0, c1.count}, c1.tc, c1.done);
    @(negedge clk);
    c0.en = 1'b0;
    expect_push("c0_101", 0, 1'b0, 1'b0);
    expect_push("c1_101", 0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    if (c1.tc) pulses++;
    check_out({28'd0, c0.count}, c0.tc, c0.done);
    check_out({28'd0, c1.count}, c1.tc, c1.done);
    @(negedge clk);
    expect_push("c1_102", 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    if (c1.tc) pulses++;
    check_out({28'd0, c1.count}, c1.tc, c1.done);
    chk("casc_pulses", pulses, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
